// File: rtl/reg_write_arbiter_pkg.sv
// Shared types and elaboration helpers for the round-robin register write arbiter.
package reg_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

    // Hold counter width; a zero-cycle hold still gets a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned hold);
        if (hold == 0) begin
            return 1;
        end
        return (hold + 1 > 2) ? $clog2(hold + 1) : 1;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, searching cyclically.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    logic [IDX_W-1:0] sel;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        sel     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sel = IDX_W'((32'(ptr) + k) % NREQ);
            if (!any && req[sel]) begin
                any      = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares one WIDTH-bit register among NREQ requesters with round-robin grants
// and a post-write hold window during which the register stays frozen.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NREQ        = 4,
    parameter int unsigned HOLD_CYCLES = 2,
    localparam int unsigned IDX_W      = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  clr,
    output logic [WIDTH-1:0]      q,
    output logic                  q_valid,
    output logic [IDX_W-1:0]      q_owner,
    output logic                  busy
);

    localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] ptr;

    logic [NREQ-1:0]  pick_gnt;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             grant_en;
    logic             transfer;
    logic [WIDTH-1:0] win_data;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .any     (pick_any)
    );

    // rst_n gates the grant directly so ready stays low during reset regardless of valid.
    always_comb begin
        grant_en  = rst_n && (state == ST_IDLE) && !clr;
        req_ready = grant_en ? pick_gnt : '0;
        transfer  = grant_en && pick_any;
    end

    always_comb begin
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                win_data = win_data | req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ptr     <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            q_owner <= '0;
            busy    <= 1'b0;
        end else begin
            // transfer already excludes clr, so the two never compete for q
            if (clr) begin
                q       <= '0;
                q_valid <= 1'b0;
            end
            unique case (state)
                ST_IDLE: begin
                    if (transfer) begin
                        q       <= win_data;
                        q_owner <= pick_idx;
                        q_valid <= 1'b1;
                        ptr     <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                        if (HOLD_CYCLES > 0) begin
                            state <= ST_HOLD;
                            busy  <= 1'b1;
                            cnt   <= HOLD_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
